// File: rtl/cond_pkg.sv
// Shared types and constants for condition evaluation: condition codes,
// flag bit positions and flag write-enable masks.
package cond_pkg;

  typedef enum logic [3:0] {
    EQ = 4'h0, NE = 4'h1, CS = 4'h2, CC = 4'h3,
    MI = 4'h4, PL = 4'h5, VS = 4'h6, VC = 4'h7,
    HI = 4'h8, LS = 4'h9, GE = 4'hA, LT = 4'hB,
    GT = 4'hC, LE = 4'hD, AL = 4'hE, NV = 4'hF
  } cond_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  localparam logic [1:0] FLAGW_NZ = 2'b10;
  localparam logic [1:0] FLAGW_CV = 2'b01;

  // NV (undefined) deliberately evaluates to 0 so the result is never X.
  function automatic logic cond_eval(input logic [3:0] cond, input logic [3:0] flags);
    logic n, z, c, v;
    n = flags[FLAG_N];
    z = flags[FLAG_Z];
    c = flags[FLAG_C];
    v = flags[FLAG_V];
    case (cond_e'(cond))
      EQ:      cond_eval = z;
      NE:      cond_eval = ~z;
      CS:      cond_eval = c;
      CC:      cond_eval = ~c;
      MI:      cond_eval = n;
      PL:      cond_eval = ~n;
      VS:      cond_eval = v;
      VC:      cond_eval = ~v;
      HI:      cond_eval = c & ~z;
      LS:      cond_eval = ~c | z;
      GE:      cond_eval = (n == v);
      LT:      cond_eval = (n != v);
      GT:      cond_eval = ~z & (n == v);
      LE:      cond_eval = z | (n != v);
      AL:      cond_eval = 1'b1;
      default: cond_eval = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/cond_logic_flags_reg.sv
// Architectural {N,Z,C,V} register with independent write enables for
// the N/Z pair and the C/V pair.
module flags_reg
  import cond_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] we,
  input  logic [3:0] flags_in,
  output logic [3:0] flags
);

  logic [3:0] flags_d, flags_q;

  always_comb begin
    flags_d = flags_q;
    if (we[1]) begin
      flags_d[FLAG_N] = flags_in[FLAG_N];
      flags_d[FLAG_Z] = flags_in[FLAG_Z];
    end
    if (we[0]) begin
      flags_d[FLAG_C] = flags_in[FLAG_C];
      flags_d[FLAG_V] = flags_in[FLAG_V];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) flags_q <= 4'b0000;
    else          flags_q <= flags_d;
  end

  assign flags = flags_q;

endmodule

// File: rtl/cond_logic.sv
// Conditional-execution unit: evaluates the condition against the current
// flags, gates control writes, and holds the result in a one-deep output stage.
module cond_logic
  import cond_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             ex_valid,
  output logic             ex_ready,
  input  logic [3:0]       Cond,
  input  logic [3:0]       ALUFlags,
  input  logic [1:0]       FlagW,
  input  logic             PCS,
  input  logic             RegW,
  input  logic             MemW,
  output logic             wb_valid,
  input  logic             wb_ready,
  output logic             PCSrc,
  output logic             RegWrite,
  output logic             MemWrite,
  output logic             CondEx_q,
  output logic [3:0]       Flags,
  output logic             cond_err,
  output logic [CNT_W-1:0] squash_cnt
);

  logic             accept;
  logic             cond_ex;
  logic [1:0]       flag_we;
  logic             wb_valid_d, wb_valid_q;
  logic             pcsrc_d, pcsrc_q;
  logic             regwrite_d, regwrite_q;
  logic             memwrite_d, memwrite_q;
  logic             cond_ex_d, cond_ex_q;
  logic             cond_err_d, cond_err_q;
  logic [CNT_W-1:0] squash_cnt_d, squash_cnt_q;

  assign ex_ready = ~wb_valid_q | wb_ready;
  assign accept   = ex_valid & ex_ready;
  // Evaluated against the pre-update flags; the flag write lands on the same
  // edge, so the next instruction sees it without a hazard.
  assign cond_ex  = cond_eval(Cond, Flags);
  assign flag_we  = (accept & cond_ex) ? FlagW : 2'b00;

  flags_reg u_flags_reg (
    .clk      (clk),
    .reset_n  (reset_n),
    .we       (flag_we),
    .flags_in (ALUFlags),
    .flags    (Flags)
  );

  always_comb begin
    wb_valid_d   = wb_valid_q;
    pcsrc_d      = pcsrc_q;
    regwrite_d   = regwrite_q;
    memwrite_d   = memwrite_q;
    cond_ex_d    = cond_ex_q;
    cond_err_d   = cond_err_q;
    squash_cnt_d = squash_cnt_q;
    if (accept) begin
      wb_valid_d = 1'b1;
      pcsrc_d    = PCS  & cond_ex;
      regwrite_d = RegW & cond_ex;
      memwrite_d = MemW & cond_ex;
      cond_ex_d  = cond_ex;
      if (Cond == NV) cond_err_d = 1'b1;
      if (!cond_ex && !(&squash_cnt_q)) squash_cnt_d = squash_cnt_q + CNT_W'(1);
    end else if (wb_ready) begin
      wb_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wb_valid_q   <= 1'b0;
      pcsrc_q      <= 1'b0;
      regwrite_q   <= 1'b0;
      memwrite_q   <= 1'b0;
      cond_ex_q    <= 1'b0;
      cond_err_q   <= 1'b0;
      squash_cnt_q <= '0;
    end else begin
      wb_valid_q   <= wb_valid_d;
      pcsrc_q      <= pcsrc_d;
      regwrite_q   <= regwrite_d;
      memwrite_q   <= memwrite_d;
      cond_ex_q    <= cond_ex_d;
      cond_err_q   <= cond_err_d;
      squash_cnt_q <= squash_cnt_d;
    end
  end

  assign wb_valid   = wb_valid_q;
  assign PCSrc      = pcsrc_q;
  assign RegWrite   = regwrite_q;
  assign MemWrite   = memwrite_q;
  assign CondEx_q   = cond_ex_q;
  assign cond_err   = cond_err_q;
  assign squash_cnt = squash_cnt_q;

endmodule

// File: tb/tb_cond_logic.sv
// Bench for cond_logic: behavioural reference model checked every cycle,
// plus directed vectors with hand-computed expectations.
module tb_cond_logic;

  localparam int CNT_W = 8;
  localparam int SQ_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             ex_valid = 1'b0;
  logic             ex_ready;
  logic [3:0]       Cond = 4'h0;
  logic [3:0]       ALUFlags = 4'h0;
  logic [1:0]       FlagW = 2'b00;
  logic             PCS = 1'b0, RegW = 1'b0, MemW = 1'b0;
  logic             wb_valid;
  logic             wb_ready = 1'b1;
  logic             PCSrc, RegWrite, MemWrite, CondEx_q;
  logic [3:0]       Flags;
  logic             cond_err;
  logic [CNT_W-1:0] squash_cnt;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  cond_logic #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .Cond(Cond), .ALUFlags(ALUFlags), .FlagW(FlagW),
    .PCS(PCS), .RegW(RegW), .MemW(MemW),
    .wb_valid(wb_valid), .wb_ready(wb_ready),
    .PCSrc(PCSrc), .RegWrite(RegWrite), .MemWrite(MemWrite), .CondEx_q(CondEx_q),
    .Flags(Flags), .cond_err(cond_err), .squash_cnt(squash_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: flags as separate booleans, results as plain bits.
  bit m_n, m_z, m_c, m_v;
  bit m_wbv, m_pcsrc, m_regw, m_memw, m_cex, m_err;
  int m_sq;

  function automatic bit m_cond(input int c, input bit n, input bit z, input bit cf, input bit v);
    case (c)
      0:  return z;
      1:  return !z;
      2:  return cf;
      3:  return !cf;
      4:  return n;
      5:  return !n;
      6:  return v;
      7:  return !v;
      8:  return cf && !z;
      9:  return !cf || z;
      10: return n == v;
      11: return n != v;
      12: return !z && (n == v);
      13: return z || (n != v);
      14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      {m_n, m_z, m_c, m_v} = 4'b0000;
      {m_wbv, m_pcsrc, m_regw, m_memw, m_cex, m_err} = 6'b0;
      m_sq = 0;
    end else begin
      bit acc, ce;
      acc = ex_valid && (!m_wbv || wb_ready);
      if (acc) begin
        ce = m_cond(int'(Cond), m_n, m_z, m_c, m_v);
        m_wbv = 1'b1;
        m_pcsrc = PCS && ce;
        m_regw = RegW && ce;
        m_memw = MemW && ce;
        m_cex = ce;
        if (Cond == 4'hF) m_err = 1'b1;
        if (!ce && m_sq < SQ_MAX) m_sq++;
        if (ce && FlagW[1]) begin m_n = ALUFlags[3]; m_z = ALUFlags[2]; end
        if (ce && FlagW[0]) begin m_c = ALUFlags[1]; m_v = ALUFlags[0]; end
      end else if (wb_ready) begin
        m_wbv = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("m_ex_ready", ex_ready, (!m_wbv || wb_ready));
      check("m_wb_valid", wb_valid, m_wbv);
      check("m_flags", Flags, {m_n, m_z, m_c, m_v});
      check("m_cond_err", cond_err, m_err);
      check("m_squash_cnt", squash_cnt, m_sq);
      check("m_outs", {PCSrc, RegWrite, MemWrite, CondEx_q}, {m_pcsrc, m_regw, m_memw, m_cex});
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit vld, input logic [3:0] c, input logic [3:0] af,
                       input logic [1:0] fw, input bit pcs, input bit rw, input bit mw);
    ex_valid = vld; Cond = c; ALUFlags = af; FlagW = fw; PCS = pcs; RegW = rw; MemW = mw;
  endtask

  initial begin
    #1;
    check("reset_ex_ready", ex_ready, 1'b1);
    check("reset_wb_valid", wb_valid, 1'b0);
    check("reset_flags", Flags, 4'b0000);
    cmp_en = 1'b1;
    cyc(); cyc();
    reset_n = 1'b1;
    cyc();

    // EQ with Z=0 from reset: squashed, flags untouched.
    drive(1, 4'h0, 4'b0100, 2'b11, 0, 0, 0);
    cyc();
    drive(0, 4'h0, 4'h0, 2'b00, 0, 0, 0);
    check("eq_squash_condex", CondEx_q, 1'b0);
    check("eq_squash_flags", Flags, 4'b0000);
    check("eq_squash_cnt", squash_cnt, 8'd1);
    cyc();

    // AL writes N,Z; next EQ sees Z=1 back-to-back.
    drive(1, 4'hE, 4'b0100, 2'b10, 0, 1, 0);
    cyc();
    check("al_regwrite", RegWrite, 1'b1);
    check("al_flags", Flags, 4'b0100);
    drive(1, 4'h0, 4'b0000, 2'b00, 0, 0, 1);
    cyc();
    check("eq_memwrite", MemWrite, 1'b1);

    // Signed compares with N=1,V=1 then N=1,V=0.
    drive(1, 4'hE, 4'b1001, 2'b11, 0, 0, 0); cyc();
    drive(1, 4'hA, 4'b0000, 2'b00, 0, 0, 0); cyc();
    check("ge_condex", CondEx_q, 1'b1);
    drive(1, 4'hB, 4'b0000, 2'b00, 0, 0, 0); cyc();
    check("lt_condex", CondEx_q, 1'b0);
    drive(1, 4'hC, 4'b0000, 2'b00, 0, 0, 0); cyc();
    check("gt_condex", CondEx_q, 1'b1);
    drive(1, 4'hE, 4'b1000, 2'b11, 0, 0, 0); cyc();
    drive(1, 4'hD, 4'b0000, 2'b00, 0, 0, 0); cyc();
    check("le_condex", CondEx_q, 1'b1);

    // Sweep all condition codes over varying flag writes.
    for (int i = 0; i < 48; i++) begin
      drive(1, 4'(i % 16), 4'(i * 5 + 3), 2'(i % 4), i[0], i[1], i[2]);
      cyc();
    end
    drive(0, 4'h0, 4'h0, 2'b00, 0, 0, 0);
    cyc();

    // Backpressure: one accept, then three stalled cycles.
    wb_ready = 1'b0;
    drive(1, 4'hE, 4'b0110, 2'b11, 0, 1, 0);
    cyc();
    check("bp_first_flags", Flags, 4'b0110);
    drive(1, 4'hE, 4'b1111, 2'b11, 1, 0, 1);
    for (int i = 0; i < 3; i++) begin
      check("bp_ex_ready", ex_ready, 1'b0);
      check("bp_hold_outs", {PCSrc, RegWrite, MemWrite}, 3'b010);
      check("bp_hold_flags", Flags, 4'b0110);
      cyc();
    end
    wb_ready = 1'b1;
    cyc();
    check("bp_release_flags", Flags, 4'b1111);
    check("bp_release_outs", {PCSrc, RegWrite, MemWrite}, 3'b101);
    drive(1, 4'h1, 4'b0000, 2'b11, 1, 1, 1);
    cyc();
    check("bp_next_squash", CondEx_q, 1'b0);

    // Undefined condition: gated, sticky error, saturating squash count.
    drive(1, 4'hF, 4'b0000, 2'b11, 1, 1, 1);
    cyc();
    check("nv_pcsrc", PCSrc, 1'b0);
    check("nv_cond_err", cond_err, 1'b1);
    for (int i = 0; i < 300; i++) cyc();
    check("squash_sat", squash_cnt, 8'd255);
    drive(1, 4'hE, 4'b0000, 2'b00, 0, 0, 0);
    cyc(); cyc();
    check("cond_err_sticky", cond_err, 1'b1);
    check("squash_sat_hold", squash_cnt, 8'd255);

    // Async reset while a result is held under backpressure.
    wb_ready = 1'b0;
    drive(1, 4'hE, 4'b1010, 2'b11, 0, 1, 0);
    cyc();
    drive(0, 4'h0, 4'h0, 2'b00, 0, 0, 0);
    check("pre_rst_wb_valid", wb_valid, 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst_wb_valid", wb_valid, 1'b0);
    check("async_rst_flags", Flags, 4'b0000);
    check("async_rst_err", cond_err, 1'b0);
    check("async_rst_ex_ready", ex_ready, 1'b1);
    cyc();
    reset_n = 1'b1;
    wb_ready = 1'b1;
    drive(1, 4'h0, 4'b0000, 2'b00, 0, 1, 0);
    cyc();
    drive(0, 4'h0, 4'h0, 2'b00, 0, 0, 0);
    check("post_rst_eq", CondEx_q, 1'b0);
    check("post_rst_cnt", squash_cnt, 8'd1);
    cyc(); cyc();

    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cond_logic.md
COND_LOGIC -- requirements
Module: cond_logic

Interface
REQ-001 SHALL have parameter CNT_W, default 8, meaning width of the squash counter.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port ex_valid  input  1  execute-stage instruction present.
REQ-005 SHALL have port ex_ready  output  1  block can accept the instruction this cycle.
REQ-006 SHALL have port Cond  input  4  instruction condition field.
REQ-007 SHALL have port ALUFlags  input  4  {N,Z,C,V} produced by the ALU for this instruction.
REQ-008 SHALL have port FlagW  input  2  bit1 = write N,Z; bit0 = write C,V.
REQ-009 SHALL have port PCS, RegW, MemW  input  1 each  unconditioned control requests.
REQ-010 SHALL have port wb_valid  output  1  registered result present.
REQ-011 SHALL have port wb_ready  input  1  consumer accepts the result.
REQ-012 SHALL have port PCSrc, RegWrite, MemWrite, CondEx_q  output  1 each  registered, condition-gated controls.
REQ-013 SHALL have port Flags  output  4  current architectural {N,Z,C,V}.
REQ-014 SHALL have port cond_err  output  1  sticky: undefined condition seen.
REQ-015 SHALL have port squash_cnt  output  CNT_W  count of accepted instructions with CondEx=0.

Function
REQ-016 Accept SHALL occur when ex_valid && ex_ready; ex_ready = ~wb_valid | wb_ready (single output register, no bubble on back-to-back).
REQ-017 CondEx SHALL be computed combinationally from Cond and the flags register value before any update this cycle.
REQ-018 Decode: 0 EQ Z; 1 NE ~Z; 2 CS C; 3 CC ~C; 4 MI N; 5 PL ~N; 6 VS V; 7 VC ~V; 8 HI C&~Z; 9 LS ~C|Z; A GE N==V; B LT N!=V; C GT ~Z&(N==V); D LE Z|(N!=V); E AL 1.
REQ-019 Cond=4'b1111 SHALL yield CondEx=0 (never X) and set cond_err on accept.
REQ-020 On accept with CondEx=1: FlagW[1] loads N,Z from ALUFlags; FlagW[0] loads C,V; visible on Flags the following cycle.
REQ-021 On accept with CondEx=0 the flags register SHALL be unchanged regardless of FlagW.
REQ-022 On accept the output register SHALL load PCSrc=PCS&CondEx, RegWrite=RegW&CondEx, MemWrite=MemW&CondEx, CondEx_q=CondEx and set wb_valid; latency 1 cycle.
REQ-023 wb_valid SHALL clear when wb_ready=1 and no new accept; outputs SHALL hold stable while wb_valid && ~wb_ready.
REQ-024 Back-to-back instructions: the second SHALL evaluate against flags written by the first (no stale-flag hazard).
REQ-025 squash_cnt SHALL increment on each accept with CondEx=0 and saturate at all-ones.
REQ-026 When not accepting, flags, cond_err and squash_cnt SHALL hold.

Reset
REQ-027 reset_n low SHALL asynchronously clear Flags=0, wb_valid=0, PCSrc=RegWrite=MemWrite=CondEx_q=0, cond_err=0, squash_cnt=0.
REQ-028 Reset mid-transfer SHALL discard the held result; first accept after release is evaluated against Flags=0.
REQ-029 ex_ready SHALL be 1 during and immediately after reset (wb_valid=0).

Structure
REQ-030 Shared package cond_pkg SHALL hold the cond_e enum (EQ..AL, NV), flag bit indices N=3,Z=2,C=1,V=0, and FLAGW_NZ/FLAGW_CV constants.
REQ-031 Flags storage with split write enables SHALL be sub-module flags_reg; evaluation, handshake and counters stay in cond_logic.

Verification
REQ-032 Reset, then Cond=0 (EQ), FlagW=2'b11, ALUFlags=4'b0100 -> CondEx_q=0 (Z=0), Flags stays 0000, squash_cnt=1.
REQ-033 Cond=E, FlagW=2'b10, ALUFlags=4'b0100, RegW=1 -> next cycle RegWrite=1, Flags=0100; following Cond=0, MemW=1 -> MemWrite=1.
REQ-034 Flags=1001 (N=1,V=1): Cond=A -> 1, Cond=B -> 0, Cond=C -> 1; Flags=1000: Cond=D -> 1.
REQ-035 Hold wb_ready=0 three cycles with ex_valid=1 -> ex_ready=0, outputs stable, no flag update; release -> one accept per cycle.
REQ-036 Cond=F with PCS=1 -> PCSrc=0, cond_err=1 persists until reset; 300 squashed accepts with CNT_W=8 -> squash_cnt=255.
REQ-037 Assert reset_n low while wb_valid=1, wb_ready=0 -> wb_valid=0, Flags=0000 immediately, without a clock edge.
